// File: rtl/cond_flag_unit.sv
// ARM-style condition evaluation and NZCV flag register with gated, registered controls.
// Optional flag save/restore shadow register enabled by defining COND_FLAG_SAVE_EN.
module cond_flag_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       flush,
  input  logic       valid_in,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
`ifdef COND_FLAG_SAVE_EN
  input  logic       save,
  input  logic       restore,
  output logic [3:0] SavedFlags,
`endif
  output logic [3:0] Flags,
  output logic       CondEx,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       valid_out
);

  logic [3:0] flags_q, flags_d;
  logic [3:0] flags_wr_s;
  logic       pcsrc_q, pcsrc_d;
  logic       regwrite_q, regwrite_d;
  logic       memwrite_q, memwrite_d;
  logic       valid_q, valid_d;
  logic       cond_ex_s;
  logic       qual_s;
`ifdef COND_FLAG_SAVE_EN
  logic [3:0] saved_q, saved_d;
`endif

  // Condition field decode against {N,Z,C,V}; 1111 is reserved and never executes.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = f;
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Qualification, per-pair flag writes and next-state of all registered outputs.
  always_comb begin
    cond_ex_s  = cond_eval(Cond, flags_q);
    qual_s     = valid_in & en & ~flush & cond_ex_s;
    flags_wr_s = flags_q;
    flags_d    = flags_q;
    pcsrc_d    = pcsrc_q;
    regwrite_d = regwrite_q;
    memwrite_d = memwrite_q;
    valid_d    = valid_q;
`ifdef COND_FLAG_SAVE_EN
    saved_d    = saved_q;
`endif
    if (en) begin
      if (qual_s & FlagW[1]) begin
        flags_wr_s[3:2] = ALUFlags[3:2];
      end else begin
        flags_wr_s[3:2] = flags_q[3:2];
      end
      if (qual_s & FlagW[0]) begin
        flags_wr_s[1:0] = ALUFlags[1:0];
      end else begin
        flags_wr_s[1:0] = flags_q[1:0];
      end
      pcsrc_d    = PCS & qual_s;
      regwrite_d = RegW & qual_s;
      memwrite_d = MemW & qual_s;
      valid_d    = valid_in & ~flush;
`ifdef COND_FLAG_SAVE_EN
      // Save captures the pre-edge flags, so save+restore together swaps.
      if (save) begin
        saved_d = flags_q;
      end else begin
        saved_d = saved_q;
      end
      if (restore) begin
        flags_d = saved_q;
      end else begin
        flags_d = flags_wr_s;
      end
`else
      flags_d = flags_wr_s;
`endif
    end else begin
      flags_d = flags_q;
    end
  end

  // State registers; stall holds everything via the next-state defaults.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q    <= 4'b0000;
      pcsrc_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memwrite_q <= 1'b0;
      valid_q    <= 1'b0;
`ifdef COND_FLAG_SAVE_EN
      saved_q    <= 4'b0000;
`endif
    end else begin
      flags_q    <= flags_d;
      pcsrc_q    <= pcsrc_d;
      regwrite_q <= regwrite_d;
      memwrite_q <= memwrite_d;
      valid_q    <= valid_d;
`ifdef COND_FLAG_SAVE_EN
      saved_q    <= saved_d;
`endif
    end
  end

  assign Flags     = flags_q;
  assign CondEx    = cond_ex_s;
  assign PCSrc     = pcsrc_q;
  assign RegWrite  = regwrite_q;
  assign MemWrite  = memwrite_q;
  assign valid_out = valid_q;
`ifdef COND_FLAG_SAVE_EN
  assign SavedFlags = saved_q;
`endif

endmodule
